data_sram_resp: RTL and testbench
=================================

Name: data_sram_resp

Overview:
- Responder (slave) end of the CPU data-SRAM interface. It serves the core's data_sram_en/wen/addr/wdata requests and returns data_sram_rdata.
- Contains an on-chip word-addressed data RAM and a small MMIO register window: LED, scratch, timer, compare, status.
- Sits beside the core at SoC top level. It replaces the external data RAM for simulation and FPGA bring-up.

Parameters:
- ADDR_W, 10, word-address bits of RAM (depth = 2^ADDR_W words).
- MMIO_BASE, 32'hBFAF_0000, base of MMIO window; decode compares addr[31:16] only.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- data_sram_en  input  1  access request this cycle
- data_sram_wen  input  4  byte write enables; 0 = read
- data_sram_addr  input  32  byte address; bits [1:0] ignored
- data_sram_wdata  input  32  write data, byte lanes per wen
- data_sram_rdata  output  32  read data, registered
- led  output  16  LED register
- timer_irq  output  1  timer interrupt pending

Behaviour:
- Decode: if addr[31:16] == MMIO_BASE[31:16] the access is MMIO, using offset addr[15:0]; otherwise it is RAM. RAM index = addr[ADDR_W+1:2]; higher bits are ignored, so addresses alias.
- Latency: every access with en=1 (read or write) loads rdata at the next rising edge. rdata is valid the cycle after the request.
- en=0: rdata holds its previous value. No other state changes except the timer.
- RAM write: en=1 and wen!=0 updates only the lanes selected by wen. Lane i covers bits [8i+7:8i].
- RAM read-during-write, same cycle and same word: rdata returns the pre-write contents (read-first).
- Back-to-back accesses are allowed every cycle. There are no stalls and no handshake beyond en.
- MMIO map (offset, reset value):
  - 0x00 LED, 0x0000: RW, bits [15:0]; upper bits read 0.
  - 0x04 SCRATCH, 0: RW, 32 bits.
  - 0x08 TIMER, 0: RW.
  - 0x0C COMPARE, 0xFFFF_FFFF: RW.
  - 0x10 STATUS: bit0 = irq pending; write 1 to clear (W1C); other bits read 0.
  - Unmapped offsets read 0; writes to them are ignored.
- MMIO writes honour wen byte lanes. Reads return the value before that cycle's update.
- Timer: TIMER increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write to TIMER in a cycle loads the written value instead of incrementing. Counting resumes from it on the next cycle.
- IRQ: pending sets at the edge where the current TIMER value == COMPARE.
  - Set and W1C clear in the same cycle: set wins.
  - timer_irq = pending bit.
- Reset: rdata = 0, led = 0, registers take the reset values above, pending = 0. RAM contents are not reset.
- Reset mid-access: a request presented while reset=1 is dropped (no write) and rdata is 0 next cycle.

Optional Feature:
- Macro: DATA_SRAM_RESP_TIMER_EN.
- Defined: TIMER, COMPARE, STATUS and timer_irq behave as above.
- Undefined:
  - The TIMER/COMPARE/STATUS registers are not built.
  - Offsets 0x08–0x10 read 0 and ignore writes.
  - timer_irq is tied to 0.
  - LED, SCRATCH and RAM are unchanged.

Test Plan:
- Reset, then read RAM addr 0x0000_0010 → no write has occurred; rdata is the prior RAM content next cycle. led=0, timer_irq=0, rdata=0 during reset.
- Write addr 0x0000_0020, wen=4'hF, wdata=0x1122_3344; then wen=4'b0100, wdata=0xAABB_CCDD; read back → 0x11BB_3344 the cycle after the read request.
- Same-cycle read/write to word 0x24 holding 0x5555_5555, new data 0xFFFF_FFFF → rdata=0x5555_5555 next cycle; a subsequent read gives 0xFFFF_FFFF.
- Write 0x1234_ABCD to MMIO_BASE+0x00 → led=0xABCD; reading it returns 0x0000_ABCD. Write addr 0x0000_0000+2^(ADDR_W+2) → aliases to RAM word 0.
- Timer (macro on):
  - Write TIMER=0xFFFF_FFFE and COMPARE=0x0000_0001 → TIMER reads 0xFFFF_FFFF, 0, 1 on successive cycles.
  - timer_irq rises the cycle after TIMER==1.
  - W1C to STATUS clears it unless it coincides with a new match, in which case it stays set.
- Macro off: read MMIO_BASE+0x08 → 0. Write 1 to STATUS → no effect; timer_irq stays 0 over 1000 cycles.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: responder end of the CPU data-SRAM bus.
// It holds a word-addressed data RAM and an MMIO window with LED,
// SCRATCH, TIMER, COMPARE and STATUS registers.
//
// Build option: define DATA_SRAM_RESP_TIMER_EN to build TIMER,
// COMPARE, STATUS and the timer interrupt. Without it, offsets
// 0x08-0x10 read 0, writes to them are ignored, and timer_irq is 0.
//
// Ports:
//   clk             in   1   all state changes on the rising edge
//   reset           in   1   synchronous, active-high
//   data_sram_en    in   1   access request this cycle
//   data_sram_wen   in   4   byte write enables, 0 = read
//   data_sram_addr  in  32   byte address, bits [1:0] ignored
//   data_sram_wdata in  32   write data, one byte lane per wen bit
//   data_sram_rdata out 32   registered read data (next cycle)
//   led             out 16   LED register
//   timer_irq       out  1   timer interrupt pending
module data_sram_resp #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic        timer_irq
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [15:0] OFF_LED  = 16'h0000;
   localparam logic [15:0] OFF_SCR  = 16'h0004;
`ifdef DATA_SRAM_RESP_TIMER_EN
   localparam logic [15:0] OFF_TMR  = 16'h0008;
   localparam logic [15:0] OFF_CMP  = 16'h000C;
   localparam logic [15:0] OFF_STAT = 16'h0010;
`endif

   function automatic logic [31:0] f_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  be
   );
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? new_v[8*i +: 8]
                               : old_v[8*i +: 8];
      end
      return res;
   endfunction

   logic              w_req;
   logic              w_is_mmio;
   logic [15:0]       w_off;
   logic [ADDR_W-1:0] w_idx;
   logic              w_wr;
   logic              w_ram_we;
   logic              w_mmio_we;
   logic              w_sel_led;
   logic              w_sel_scr;
   logic [31:0]       w_ram_rd;
   logic [31:0]       w_mmio_rd;

   logic [31:0]       r_mem [DEPTH];
   logic [31:0]       r_rdata;
   logic [15:0]       r_led;
   logic [31:0]       r_scratch;

   // A request seen during reset is dropped entirely.
   assign w_req     = data_sram_en & ~reset;
   assign w_is_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
   assign w_off     = data_sram_addr[15:0];
   assign w_idx     = data_sram_addr[ADDR_W+1:2];
   assign w_wr      = w_req & (|data_sram_wen);
   assign w_ram_we  = w_wr & ~w_is_mmio;
   assign w_mmio_we = w_wr & w_is_mmio;
   assign w_sel_led = (w_off == OFF_LED);
   assign w_sel_scr = (w_off == OFF_SCR);

   // RAM: per-lane write. The read port below samples the old word
   // in the same edge, so a same-word write reads first.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
               r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   assign w_ram_rd = r_mem[w_idx];

`ifdef DATA_SRAM_RESP_TIMER_EN
   logic        w_sel_tmr;
   logic        w_sel_cmp;
   logic        w_sel_stat;
   logic        w_match;
   logic        w_w1c;
   logic [31:0] r_timer;
   logic [31:0] r_compare;
   logic        r_pend;

   assign w_sel_tmr  = (w_off == OFF_TMR);
   assign w_sel_cmp  = (w_off == OFF_CMP);
   assign w_sel_stat = (w_off == OFF_STAT);
   assign w_match    = (r_timer == r_compare);
   assign w_w1c      = w_mmio_we & w_sel_stat &
                       data_sram_wen[0] & data_sram_wdata[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer <= 32'h0;
      end else if (w_mmio_we & w_sel_tmr) begin
         r_timer <= f_merge(r_timer, data_sram_wdata,
                            data_sram_wen);
      end else begin
         r_timer <= r_timer + 32'h1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_compare <= 32'hFFFF_FFFF;
      end else if (w_mmio_we & w_sel_cmp) begin
         r_compare <= f_merge(r_compare, data_sram_wdata,
                              data_sram_wen);
      end
   end

   // A new match outranks a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= 1'b0;
      end else begin
         r_pend <= w_match | (r_pend & ~w_w1c);
      end
   end

   assign timer_irq = r_pend;
`else
   assign timer_irq = 1'b0;
`endif

   always_comb begin
      w_mmio_rd = 32'h0;
      unique case (1'b1)
         w_sel_led:  w_mmio_rd = {16'h0, r_led};
         w_sel_scr:  w_mmio_rd = r_scratch;
`ifdef DATA_SRAM_RESP_TIMER_EN
         w_sel_tmr:  w_mmio_rd = r_timer;
         w_sel_cmp:  w_mmio_rd = r_compare;
         w_sel_stat: w_mmio_rd = {31'h0, r_pend};
`endif
         default:    w_mmio_rd = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_led <= 16'h0;
      end else if (w_mmio_we & w_sel_led) begin
         r_led <= f_merge({16'h0, r_led}, data_sram_wdata,
                          data_sram_wen) & 32'h0000_FFFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scratch <= 32'h0;
      end else if (w_mmio_we & w_sel_scr) begin
         r_scratch <= f_merge(r_scratch, data_sram_wdata,
                              data_sram_wen);
      end
   end

   // Reads and writes both load rdata; idle cycles hold it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= 32'h0;
      end else if (data_sram_en) begin
         r_rdata <= w_is_mmio ? w_mmio_rd : w_ram_rd;
      end
   end

   assign data_sram_rdata = r_rdata;
   assign led             = r_led;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed scoreboard bench for data_sram_resp.
// Stimulus pushes expectations; a monitor pops and checks rdata.
module tb_data_sram_resp;

   localparam int          ADDR_W = 10;
   localparam logic [31:0] MB     = 32'hBFAF_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] led;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];

   data_sram_resp #(
      .ADDR_W    (ADDR_W),
      .MMIO_BASE (MB)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .led             (led),
      .timer_irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic e, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic c, input logic [31:0] x,
                      input string nm);
      exp_t ent;
      en    = e;
      wen   = w;
      addr  = a;
      wdata = d;
      if (e) begin
         ent.chk  = c;
         ent.exp  = x;
         ent.name = nm;
         sb.push_back(ent);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] w);
      cyc(1'b1, w, a, d, 1'b0, 32'h0, "wr");
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] x,
                     input string nm);
      cyc(1'b1, 4'h0, a, 32'h0, 1'b1, x, nm);
   endtask

   task automatic idle();
      cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "idle");
   endtask

   // Monitor: a request taken at a rising edge is checked at the
   // following falling edge.
   initial begin
      logic smp;
      exp_t ent;
      forever begin
         @(posedge clk);
         smp = en;
         @(negedge clk);
         if (smp) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL sb_underflow: got response want none");
            end else begin
               ent = sb.pop_front();
               if (ent.chk) check(ent.name, rdata, ent.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      en    = 1'b0;
      wen   = 4'h0;
      addr  = 32'h0;
      wdata = 32'h0;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_rdata", rdata, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      reset = 1'b0;

      wr(32'h10, 32'h0BAD_F00D, 4'hF);
      wr(MB, 32'h0000_00FF, 4'hF);
      check("led_ff", {16'h0, led}, 32'h0000_00FF);
      rd(32'h10, 32'h0BAD_F00D, "ram_pre");

      reset = 1'b1;
      cyc(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0,
          "rst_drop_rdata");
      check("rst2_led", {16'h0, led}, 32'h0);
      reset = 1'b0;
      rd(32'h10, 32'h0BAD_F00D, "rst_no_write");
      idle();
      check("hold", rdata, 32'h0BAD_F00D);

      wr(32'h20, 32'h1122_3344, 4'hF);
      wr(32'h20, 32'hAABB_CCDD, 4'b0100);
      rd(32'h20, 32'h11BB_3344, "lane");

      wr(32'h24, 32'h5555_5555, 4'hF);
      cyc(1'b1, 4'hF, 32'h24, 32'hFFFF_FFFF, 1'b1, 32'h5555_5555,
          "rfw_old");
      rd(32'h24, 32'hFFFF_FFFF, "rfw_new");

      wr(32'h0000_1000, 32'hCAFE_0001, 4'hF);
      rd(32'h0, 32'hCAFE_0001, "alias");

      wr(MB, 32'h1234_ABCD, 4'hF);
      check("led_abcd", {16'h0, led}, 32'h0000_ABCD);
      rd(MB, 32'h0000_ABCD, "led_rd");
      wr(MB, 32'h0000_5600, 4'b0010);
      rd(MB, 32'h0000_56CD, "led_lane");

      wr(MB + 32'h4, 32'hDEAD_BEEF, 4'hF);
      wr(MB + 32'h4, 32'h7700_0000, 4'b1000);
      rd(MB + 32'h4, 32'h77AD_BEEF, "scratch");
      cyc(1'b1, 4'hF, MB + 32'h4, 32'h0, 1'b1, 32'h77AD_BEEF,
          "mmio_rfw");
      rd(MB + 32'h4, 32'h0, "scratch_clr");

      wr(MB + 32'h14, 32'hFFFF_FFFF, 4'hF);
      rd(MB + 32'h14, 32'h0, "unmapped_14");
      rd(MB + 32'h1000, 32'h0, "unmapped_1000");
      rd(32'hBFAE_0000, 32'hCAFE_0001, "near_base_ram");

`ifdef DATA_SRAM_RESP_TIMER_EN
      wr(MB + 32'hC, 32'h1, 4'hF);
      wr(MB + 32'h8, 32'hFFFF_FFFE, 4'hF);
      idle();
      rd(MB + 32'h8, 32'hFFFF_FFFF, "tmr0");
      rd(MB + 32'h8, 32'h0, "tmr1");
      check("irq_pre", {31'h0, irq}, 32'h0);
      rd(MB + 32'h8, 32'h1, "tmr2");
      check("irq_set", {31'h0, irq}, 32'h1);
      rd(MB + 32'h10, 32'h1, "status_rd");
      wr(MB + 32'h10, 32'h1, 4'hF);
      check("irq_w1c", {31'h0, irq}, 32'h0);
      wr(MB + 32'hC, 32'd100, 4'hF);
      wr(MB + 32'h8, 32'd99, 4'hF);
      idle();
      wr(MB + 32'h10, 32'h1, 4'hF);
      check("irq_set_wins", {31'h0, irq}, 32'h1);
      wr(MB + 32'h10, 32'h1, 4'hF);
      check("irq_w1c2", {31'h0, irq}, 32'h0);
`else
      rd(MB + 32'h8, 32'h0, "tmr_off");
      wr(MB + 32'hC, 32'h5, 4'hF);
      rd(MB + 32'hC, 32'h0, "cmp_off");
      wr(MB + 32'h10, 32'h1, 4'hF);
      rd(MB + 32'h10, 32'h0, "stat_off");
      hits = 0;
      for (int i = 0; i < 1000; i++) begin
         idle();
         if (irq) hits++;
      end
      check("irq_off", 32'(hits), 32'h0);
`endif

      idle();
      idle();
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
